// File: rtl/next_pc_unit_if.sv
// next_pc_unit_if: signal bundle between the control/datapath side and the
// next-PC unit.
//   master : drives step control, decoded flags and operands; reads PC/status.
//   slave  : the next-PC unit; reads control/operands, drives PC/status.
interface next_pc_unit_if;
    logic        en;
    logic        go;
    logic        JMP;
    logic        JR;
    logic        Beq;
    logic        Bne;
    logic        BLTZ;
    logic        Syscall;
    logic        equal;
    logic [31:0] rs_data;
    logic [31:0] v0_data;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [31:0] cycle_count;
    logic [15:0] jump_count;
    logic [15:0] branch_count;

    modport master (
        output en, go, JMP, JR, Beq, Bne, BLTZ, Syscall, equal,
               rs_data, v0_data, imm16, instr_index,
        input  pc, pc_plus4, halted, cycle_count, jump_count, branch_count
    );

    modport slave (
        input  en, go, JMP, JR, Beq, Bne, BLTZ, Syscall, equal,
               rs_data, v0_data, imm16, instr_index,
        output pc, pc_plus4, halted, cycle_count, jump_count, branch_count
    );
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: program-counter sequencer with RUN/HALT control.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : slave side of next_pc_unit_if.
//              inputs  en (step tick), go (resume), JMP/JR/Beq/Bne/BLTZ/Syscall,
//                      equal, rs_data, v0_data, imm16, instr_index
//              outputs pc (registered), pc_plus4 (combinational), halted,
//                      cycle_count, jump_count, branch_count
module next_pc_unit (
    input  logic           clk,
    input  logic           rst,
    next_pc_unit_if.slave  bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] pc_r, pc_next;
    logic [31:0] cycle_r, cycle_next;
    logic [15:0] jump_r, jump_next;
    logic [15:0] branch_r, branch_next;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic        display_call;

    assign pc_plus4      = pc_r + 32'd4;
    assign branch_target = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign jump_target   = {pc_plus4[31:28], bus.instr_index, 2'b00};
    assign jr_target     = {bus.rs_data[31:2], 2'b00};
    assign branch_taken  = (bus.Beq & bus.equal) | (bus.Bne & ~bus.equal) |
                           (bus.BLTZ & bus.rs_data[31]);
    // $v0 == 34 is the print service: execution continues without halting.
    assign display_call  = (bus.v0_data == 32'd34);

    always_comb begin
        state_next  = state;
        pc_next     = pc_r;
        cycle_next  = cycle_r;
        jump_next   = jump_r;
        branch_next = branch_r;
        unique case (state)
            RUN: begin
                if (bus.en) begin
                    cycle_next = cycle_r + 32'd1;
                    // Syscall overrides every jump/branch flag on the same step.
                    if (bus.Syscall) begin
                        if (display_call) begin
                            pc_next = pc_plus4;
                        end else begin
                            state_next = HALT;
                        end
                    end else begin
                        if (bus.JR) begin
                            pc_next = jr_target;
                        end else if (bus.JMP) begin
                            pc_next = jump_target;
                        end else if (branch_taken) begin
                            pc_next = branch_target;
                        end else begin
                            pc_next = pc_plus4;
                        end
                        if (bus.JMP && jump_r != '1) begin
                            jump_next = jump_r + 16'd1;
                        end
                        if (branch_taken && !bus.JMP && branch_r != '1) begin
                            branch_next = branch_r + 16'd1;
                        end
                    end
                end
            end
            HALT: begin
                if (bus.en && bus.go) begin
                    pc_next    = pc_plus4;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc_r     <= '0;
            cycle_r  <= '0;
            jump_r   <= '0;
            branch_r <= '0;
        end else begin
            state    <= state_next;
            pc_r     <= pc_next;
            cycle_r  <= cycle_next;
            jump_r   <= jump_next;
            branch_r <= branch_next;
        end
    end

    assign bus.pc           = pc_r;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.halted       = (state == HALT);
    assign bus.cycle_count  = cycle_r;
    assign bus.jump_count   = jump_r;
    assign bus.branch_count = branch_r;
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: table-driven check of next_pc_unit with a scoreboard queue
// of expected post-edge state, plus hand sequences for reset-in-halt and
// counter saturation.
module tb_next_pc_unit;
    typedef struct {
        string       name;
        logic        rst, en, go, jmp, jr, beq, bne, bltz, sys, equal;
        logic [31:0] rs, v0;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] exp_pc;
        logic        exp_halted;
        logic [31:0] exp_cycles;
        logic [15:0] exp_jumps;
        logic [15:0] exp_branches;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    next_pc_unit_if bus ();

    next_pc_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string n,
        input logic r, e, g, j, jr, bq, bn, bl, s, eq,
        input logic [31:0] rs, v0,
        input logic [15:0] imm,
        input logic [25:0] idx,
        input logic [31:0] p,
        input logic h,
        input logic [31:0] c,
        input logic [15:0] jc, bc
    );
        vec_t v;
        v.name = n; v.rst = r; v.en = e; v.go = g; v.jmp = j; v.jr = jr;
        v.beq = bq; v.bne = bn; v.bltz = bl; v.sys = s; v.equal = eq;
        v.rs = rs; v.v0 = v0; v.imm = imm; v.idx = idx;
        v.exp_pc = p; v.exp_halted = h; v.exp_cycles = c;
        v.exp_jumps = jc; v.exp_branches = bc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst             = v.rst;
        bus.en          = v.en;
        bus.go          = v.go;
        bus.JMP         = v.jmp;
        bus.JR          = v.jr;
        bus.Beq         = v.beq;
        bus.Bne         = v.bne;
        bus.BLTZ        = v.bltz;
        bus.Syscall     = v.sys;
        bus.equal       = v.equal;
        bus.rs_data     = v.rs;
        bus.v0_data     = v.v0;
        bus.imm16       = v.imm;
        bus.instr_index = v.idx;
    endtask

    task automatic check_one();
        vec_t        e;
        logic [31:0] exp_p4;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_empty: no expected record queued");
            return;
        end
        e = exp_q.pop_front();
        exp_p4 = e.exp_pc + 32'd4;
        n_vec++;
        if (bus.pc !== e.exp_pc || bus.pc_plus4 !== exp_p4 ||
            bus.halted !== e.exp_halted || bus.cycle_count !== e.exp_cycles ||
            bus.jump_count !== e.exp_jumps || bus.branch_count !== e.exp_branches) begin
            n_bad++;
            $display("FAIL %s: got pc=%h p4=%h h=%b cyc=%0d j=%0d b=%0d, want pc=%h p4=%h h=%b cyc=%0d j=%0d b=%0d",
                     e.name, bus.pc, bus.pc_plus4, bus.halted, bus.cycle_count,
                     bus.jump_count, bus.branch_count, e.exp_pc, exp_p4,
                     e.exp_halted, e.exp_cycles, e.exp_jumps, e.exp_branches);
        end
    endtask

    // Drive at negedge, clock once, sample 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input bit chk);
        @(negedge clk);
        drive(v);
        if (chk) exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (chk) check_one();
    endtask

    initial begin
        vec_t v;
        //              name        r  e  g  j  jr bq bn bl s  eq rs            v0     imm       idx          exp_pc        h  cyc  j  b
        tbl.push_back(mk("reset",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000000, 0, 0,  0, 0));
        tbl.push_back(mk("seq0",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000004, 0, 1,  0, 0));
        tbl.push_back(mk("seq1",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000008, 0, 2,  0, 0));
        tbl.push_back(mk("seq2",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h0000000C, 0, 3,  0, 0));
        tbl.push_back(mk("en_low",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h5,       32'h0000000C, 0, 3,  0, 0));
        tbl.push_back(mk("go_run",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000010, 0, 4,  0, 0));
        tbl.push_back(mk("beq_tk",   0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0,        32'd0, 16'hFFFE, 26'h0,       32'h0000000C, 0, 5,  0, 1));
        tbl.push_back(mk("step",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000010, 0, 6,  0, 1));
        tbl.push_back(mk("beq_nt",   0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,        32'd0, 16'hFFFE, 26'h0,       32'h00000014, 0, 7,  0, 1));
        tbl.push_back(mk("bne_tk",   0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        32'd0, 16'h0003, 26'h0,       32'h00000024, 0, 8,  0, 2));
        tbl.push_back(mk("bltz_tk",  0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80000000, 32'd0, 16'h0001, 26'h0,       32'h0000002C, 0, 9,  0, 3));
        tbl.push_back(mk("bltz_nt",  0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h7FFFFFFF, 32'd0, 16'h0001, 26'h0,       32'h00000030, 0, 10, 0, 3));
        tbl.push_back(mk("jmp_ovr_b",0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 32'h0,        32'd0, 16'h0001, 26'h40,      32'h00000100, 0, 11, 1, 3));
        tbl.push_back(mk("jr_hi",    0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h30000000, 32'd0, 16'h0,    26'h3,       32'h30000000, 0, 12, 2, 3));
        tbl.push_back(mk("jmp_seg",  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0000100, 32'h30000400, 0, 13, 3, 3));
        tbl.push_back(mk("jr_align", 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h00000047, 32'd0, 16'h0,    26'h0,       32'h00000044, 0, 14, 4, 3));
        tbl.push_back(mk("sys34",    0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 32'h0,        32'd34,16'h0010, 26'h0,       32'h00000048, 0, 15, 4, 3));
        tbl.push_back(mk("jr_20",    0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h00000020, 32'd0, 16'h0,    26'h0,       32'h00000020, 0, 16, 5, 3));
        tbl.push_back(mk("sys_halt", 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,        32'd10,16'h0,    26'h5,       32'h00000020, 1, 17, 5, 3));
        tbl.push_back(mk("halt_j",   0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h7,       32'h00000020, 1, 17, 5, 3));
        tbl.push_back(mk("halt_jr",  0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h100,      32'd0, 16'h0,    26'h0,       32'h00000020, 1, 17, 5, 3));
        tbl.push_back(mk("halt_beq", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0,        32'd0, 16'h0004, 26'h0,       32'h00000020, 1, 17, 5, 3));
        tbl.push_back(mk("halt_sys", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'd34,16'h0,    26'h0,       32'h00000020, 1, 17, 5, 3));
        tbl.push_back(mk("halt_idle",0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000020, 1, 17, 5, 3));
        tbl.push_back(mk("go_en0",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000020, 1, 17, 5, 3));
        tbl.push_back(mk("resume",   0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h9,       32'h00000024, 0, 17, 5, 3));
        tbl.push_back(mk("jr_top",   0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd0, 16'h0,    26'h0,       32'hFFFFFFFC, 0, 18, 6, 3));
        tbl.push_back(mk("pc_wrap",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000000, 0, 19, 6, 3));
        tbl.push_back(mk("br_wrap",  0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0,        32'd0, 16'hFFFE, 26'h0,       32'hFFFFFFFC, 0, 20, 6, 4));
        // Reset while halted with en/go asserted.
        tbl.push_back(mk("jr_40",    0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h00000040, 32'd0, 16'h0,    26'h0,       32'h00000040, 0, 21, 7, 4));
        tbl.push_back(mk("halt2",    0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000040, 1, 22, 7, 4));
        tbl.push_back(mk("rst_halt", 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h9,       32'h00000000, 0, 0,  0, 0));
        tbl.push_back(mk("post_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'd0, 16'h0,    26'h0,       32'h00000004, 0, 1,  0, 0));
        // Reset mid-run overrides a jump.
        tbl.push_back(mk("rst_run",  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h80,       32'd0, 16'h0,    26'h0,       32'h00000000, 0, 0,  0, 0));

        drive(mk("init", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'd0, 16'h0, 26'h0, 32'h0, 0, 0, 0, 0));
        for (int unsigned i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b1);
        end

        // Saturation: 65534 unchecked jumps, then check the 65535th and beyond.
        v = mk("sat_jmp", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'd0, 16'h0, 26'h0, 32'h0, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 65534; i++) begin
            apply(v, 1'b0);
        end
        v.name = "jmp_65535";  v.exp_cycles = 32'd65535; v.exp_jumps = 16'hFFFF;
        apply(v, 1'b1);
        v.name = "jmp_sat1";   v.exp_cycles = 32'd65536;
        apply(v, 1'b1);
        v.name = "jmp_sat2";   v.exp_cycles = 32'd65537;
        apply(v, 1'b1);
        v = mk("br_after_sat", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 32'd0, 16'h0001, 26'h0,
               32'h00000008, 0, 65538, 16'hFFFF, 1);
        apply(v, 1'b1);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d records left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want finish before 2000000");
        $fatal(1);
    end
endmodule
